// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Definitions shared by the single-precision FPU blocks (divider, multiplier,
// adder).
//   - Field widths and the exponent bias.
//   - Canonical special encodings (quiet NaN, +infinity).
//   - Divider state encoding.
//   - Exception flag bit positions in the flags vector
//     {invalid, div_by_zero, overflow, underflow, inexact}.
// -----------------------------------------------------------------------------
package fp32_pkg;

   localparam int FP_WIDTH     = 32;
   localparam int FP_EXP_WIDTH = 8;
   localparam int FP_MAN_WIDTH = 23;
   localparam int EXP_BIAS     = (1 << (FP_EXP_WIDTH - 1)) - 1;

   localparam logic [FP_WIDTH-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [FP_WIDTH-1:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      DIV   = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } div_state_t;

   localparam int FLAG_WIDTH       = 5;
   localparam int FLAG_INVALID     = 4;
   localparam int FLAG_DIV_BY_ZERO = 3;
   localparam int FLAG_OVERFLOW    = 2;
   localparam int FLAG_UNDERFLOW   = 1;
   localparam int FLAG_INEXACT     = 0;

endpackage

// File: rtl/fp_divider_seq_if.sv
// -----------------------------------------------------------------------------
// fp_divider_seq_if
// Operand/result handshake bundle of the sequential FP divider.
//   in_valid / in_ready          : operand handshake (master -> slave)
//   floating1_in / floating2_in  : dividend / divisor
//   out_valid / out_ready        : result handshake (slave -> master)
//   floating_division_out        : quotient
//   flags                        : exception flags, present only when
//                                  FP_DIV_EXCEPTION_FLAGS_EN is defined
// Modports: master = producer of operands / consumer of results,
//           slave  = the divider.
// -----------------------------------------------------------------------------
interface fp_divider_seq_if
   import fp32_pkg::*;
#(
   parameter int D_WIDTH = FP_WIDTH
);

   logic               in_valid;
   logic               in_ready;
   logic [D_WIDTH-1:0] floating1_in;
   logic [D_WIDTH-1:0] floating2_in;
   logic               out_valid;
   logic               out_ready;
   logic [D_WIDTH-1:0] floating_division_out;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
   logic [FLAG_WIDTH-1:0] flags;
`endif

   modport master (
      output in_valid, floating1_in, floating2_in, out_ready,
      input  in_ready, out_valid, floating_division_out
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
      , input flags
`endif
   );

   modport slave (
      input  in_valid, floating1_in, floating2_in, out_ready,
      output in_ready, out_valid, floating_division_out
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
      , output flags
`endif
   );

endinterface

// File: rtl/fp_special_classify.sv
// -----------------------------------------------------------------------------
// fp_special_classify
// Combinational classification of one IEEE 754 operand, shared by the
// divider, multiplier and adder.
//   i_exp       : biased exponent field
//   i_man       : stored mantissa field
//   o_is_zero   : exponent and mantissa both zero
//   o_is_inf    : exponent all ones, mantissa zero
//   o_is_nan    : exponent all ones, mantissa non-zero
//   o_is_denorm : exponent zero, mantissa non-zero
// -----------------------------------------------------------------------------
module fp_special_classify
   import fp32_pkg::*;
#(
   parameter int EXP_WIDTH = FP_EXP_WIDTH,
   parameter int MAN_WIDTH = FP_MAN_WIDTH
) (
   input  logic [EXP_WIDTH-1:0] i_exp,
   input  logic [MAN_WIDTH-1:0] i_man,
   output logic                 o_is_zero,
   output logic                 o_is_inf,
   output logic                 o_is_nan,
   output logic                 o_is_denorm
);

   logic w_exp_zero;
   logic w_exp_ones;
   logic w_man_zero;

   assign w_exp_zero = (i_exp == '0);
   assign w_exp_ones = &i_exp;
   assign w_man_zero = (i_man == '0);

   assign o_is_zero   = w_exp_zero &  w_man_zero;
   assign o_is_denorm = w_exp_zero & ~w_man_zero;
   assign o_is_inf    = w_exp_ones &  w_man_zero;
   assign o_is_nan    = w_exp_ones & ~w_man_zero;

endmodule

// File: rtl/fp_divider_seq.sv
// -----------------------------------------------------------------------------
// fp_divider_seq
// Iterative IEEE 754 single-precision divider, quotient = dividend / divisor.
// Restoring division produces one quotient bit per clock, followed by one
// round-to-nearest-even cycle. Denormal inputs are treated as zero and
// results that would be denormal flush to signed zero.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   bus    : fp_divider_seq_if.slave (operand and result handshakes)
// Optional build macro FP_DIV_EXCEPTION_FLAGS_EN adds bus.flags =
// {invalid, div_by_zero, overflow, underflow, inexact}, registered with the
// result and cleared when the block returns to idle.
// Latency from the accepting edge: 28 edges for normal operands, 2 edges for
// special operands (these skip DIV and pass straight through ROUND).
// -----------------------------------------------------------------------------
module fp_divider_seq
   import fp32_pkg::*;
#(
   parameter int D_WIDTH   = FP_WIDTH,
   parameter int EXP_WIDTH = FP_EXP_WIDTH,
   parameter int MAN_WIDTH = FP_MAN_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_divider_seq_if.slave bus
);

   localparam int MW = MAN_WIDTH + 1;   // mantissa with hidden bit
   localparam int RW = MAN_WIDTH + 2;   // remainder, holds up to 2*mb
   localparam int QW = MAN_WIDTH + 3;   // quotient bits = iterations
   localparam int EW = EXP_WIDTH + 2;   // signed working exponent
   localparam int CW = $clog2(QW);

   localparam logic signed [EW-1:0] L_BIAS     = EW'((1 << (EXP_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] L_EXP_MAX  = EW'((1 << EXP_WIDTH) - 1);
   localparam logic signed [EW-1:0] L_EXP_ZERO = '0;
   localparam logic signed [EW-1:0] L_EXP_ONE  = EW'(1);
   localparam logic [CW-1:0]        L_LAST_IT  = CW'(QW - 1);

   // Control / output registers
   div_state_t         r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [D_WIDTH-1:0] r_result;
   logic               r_special;
   logic [CW-1:0]      r_cnt;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
   logic [FLAG_WIDTH-1:0] r_flags;
`endif

   // Datapath registers
   logic [D_WIDTH-1:0]    r_a;
   logic [D_WIDTH-1:0]    r_b;
   logic                  r_sign;
   logic signed [EW-1:0]  r_exp;
   logic [MW-1:0]         r_mb;
   logic [RW-1:0]         r_rem;
   logic [QW-1:0]         r_q;

   // ---------------------------------------------------------------- classify
   logic w_a_zero_raw, w_a_inf, w_a_nan, w_a_denorm;
   logic w_b_zero_raw, w_b_inf, w_b_nan, w_b_denorm;

   fp_special_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_class_a (
      .i_exp       (r_a[D_WIDTH-2 -: EXP_WIDTH]),
      .i_man       (r_a[MAN_WIDTH-1:0]),
      .o_is_zero   (w_a_zero_raw),
      .o_is_inf    (w_a_inf),
      .o_is_nan    (w_a_nan),
      .o_is_denorm (w_a_denorm)
   );

   fp_special_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_class_b (
      .i_exp       (r_b[D_WIDTH-2 -: EXP_WIDTH]),
      .i_man       (r_b[MAN_WIDTH-1:0]),
      .o_is_zero   (w_b_zero_raw),
      .o_is_inf    (w_b_inf),
      .o_is_nan    (w_b_nan),
      .o_is_denorm (w_b_denorm)
   );

   logic w_a_zero, w_b_zero;
   logic w_res_nan, w_res_inf, w_res_zero, w_special, w_div_by_zero;
   logic w_sign;
   logic signed [EW-1:0] w_exp_pre;
   logic [D_WIDTH-1:0]   w_special_res;

   assign w_a_zero = w_a_zero_raw | w_a_denorm;
   assign w_b_zero = w_b_zero_raw | w_b_denorm;
   assign w_sign   = r_a[D_WIDTH-1] ^ r_b[D_WIDTH-1];

   // Priority: NaN cases first, then infinity, then zero, so each later
   // term may assume the earlier ones are false.
   assign w_res_nan     = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
   assign w_res_inf     = ~w_res_nan & (w_a_inf | w_b_zero);
   assign w_res_zero    = ~w_res_nan & ~w_res_inf & (w_a_zero | w_b_inf);
   assign w_special     = w_res_nan | w_res_inf | w_res_zero;
   assign w_div_by_zero = ~w_res_nan & w_b_zero & ~w_a_inf;

   assign w_exp_pre = $signed({2'b00, r_a[D_WIDTH-2 -: EXP_WIDTH]})
                    - $signed({2'b00, r_b[D_WIDTH-2 -: EXP_WIDTH]}) + L_BIAS;

   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_special_res = '0;
      if (w_res_nan)      w_special_res = D_WIDTH'(QNAN);
      else if (w_res_inf) w_special_res = {w_sign, POS_INF[D_WIDTH-2:0]};
      else                w_special_res = {w_sign, {(D_WIDTH-1){1'b0}}};
   end

   // --------------------------------------------------------- divide step
   logic          w_ge;
   logic [RW-1:0] w_rem_sub;

   assign w_ge      = (r_rem >= {1'b0, r_mb});
   assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

   // --------------------------------------------------------------- round
   logic                 w_norm, w_guard, w_sticky, w_rnd_up, w_carry, w_ovf, w_unf;
   logic [MW-1:0]        w_mant;
   logic [MW:0]          w_mant_sum;
   logic signed [EW-1:0] w_exp_adj, w_exp_fin;
   logic [D_WIDTH-1:0]   w_round_res;

   always_comb begin
      w_norm   = r_q[QW-1];
      w_mant   = '0;
      w_guard  = 1'b0;
      w_sticky = 1'b0;
      w_exp_adj = r_exp;
      if (w_norm) begin
         w_mant   = r_q[QW-1:2];
         w_guard  = r_q[1];
         w_sticky = r_q[0] | (|r_rem);
      end else begin
         // Quotient below 1.0: take one more bit and compensate the exponent.
         w_mant    = r_q[QW-2:1];
         w_guard   = r_q[0];
         w_sticky  = |r_rem;
         w_exp_adj = r_exp - L_EXP_ONE;
      end
      w_rnd_up   = w_guard & (w_sticky | w_mant[0]);
      w_mant_sum = {1'b0, w_mant} + {{MW{1'b0}}, w_rnd_up};
      // A carry-out leaves the low field bits all zero, so only the exponent
      // needs adjusting.
      w_carry    = w_mant_sum[MW];
      w_exp_fin  = w_exp_adj + $signed({{(EW-1){1'b0}}, w_carry});
      w_ovf      = (w_exp_fin >= L_EXP_MAX);
      w_unf      = (w_exp_fin <= L_EXP_ZERO);
      if (w_ovf)      w_round_res = {r_sign, POS_INF[D_WIDTH-2:0]};
      else if (w_unf) w_round_res = {r_sign, {(D_WIDTH-1){1'b0}}};
      else            w_round_res = {r_sign, w_exp_fin[EXP_WIDTH-1:0], w_mant_sum[MAN_WIDTH-1:0]};
   end

`ifdef FP_DIV_EXCEPTION_FLAGS_EN
   logic [FLAG_WIDTH-1:0] w_special_flags, w_round_flags;

   always_comb begin
      w_special_flags = '0;
      w_special_flags[FLAG_INVALID]     = w_res_nan;
      w_special_flags[FLAG_DIV_BY_ZERO] = w_div_by_zero;
      w_round_flags = '0;
      w_round_flags[FLAG_OVERFLOW]  = w_ovf;
      w_round_flags[FLAG_UNDERFLOW] = w_unf;
      w_round_flags[FLAG_INEXACT]   = w_guard | w_sticky | w_ovf | w_unf;
   end
`endif

   // ------------------------------------------------------------- control
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_special   <= 1'b0;
         r_cnt       <= '0;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
         r_flags     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_in_ready <= 1'b0;
                  r_state    <= PREP;
               end
            end
            PREP: begin
               r_cnt     <= '0;
               r_special <= w_special;
               if (w_special) begin
                  r_result <= w_special_res;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
                  r_flags  <= w_special_flags;
`endif
                  r_state  <= ROUND;
               end else begin
                  r_state  <= DIV;
               end
            end
            DIV: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == L_LAST_IT) r_state <= ROUND;
            end
            ROUND: begin
               if (!r_special) begin
                  r_result <= w_round_res;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
                  r_flags  <= w_round_flags;
`endif
               end
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
                  r_flags     <= '0;
`endif
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath
   // NOTE: datapath registers have no reset; each is loaded before it is
   // read, so the reset of the control registers alone defines behaviour.
   always_ff @(posedge clk) begin
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               r_a <= bus.floating1_in;
               r_b <= bus.floating2_in;
            end
         end
         PREP: begin
            r_sign <= w_sign;
            r_exp  <= w_exp_pre;
            r_rem  <= {2'b01, r_a[MAN_WIDTH-1:0]};
            r_mb   <= {1'b1, r_b[MAN_WIDTH-1:0]};
            r_q    <= '0;
         end
         DIV: begin
            r_rem <= {w_rem_sub[RW-2:0], 1'b0};
            r_q   <= {r_q[QW-2:0], w_ge};
         end
         default: ;
      endcase
   end

   assign bus.in_ready              = r_in_ready;
   assign bus.out_valid             = r_out_valid;
   assign bus.floating_division_out = r_result;
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
   assign bus.flags                 = r_flags;
`endif

endmodule

// File: tb/tb_fp_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_divider_seq
// Self-checking bench for fp_divider_seq: directed cases, backpressure,
// busy-time in_valid, mid-operation reset and randomized operands compared
// against an integer-arithmetic reference model of the division rules.
// Honours FP_DIV_EXCEPTION_FLAGS_EN for the flags output.
// -----------------------------------------------------------------------------
module tb_fp_divider_seq;
   import fp32_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fp_divider_seq_if bus ();

   fp_divider_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: quotient from 64-bit integer division of the scaled
   // mantissas, then the rounding / flush rules applied directly.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [4:0] flg,
                                 output bit spec);
      int ea, eb, e;
      bit an, ai, az, bn, bi, bz, s, g, st;
      longint unsigned ma, mb, num, q, r, mant;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      an = (ea == 255) && (a[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      az = (ea == 0);
      bn = (eb == 255) && (b[22:0] != 0);
      bi = (eb == 255) && (b[22:0] == 0);
      bz = (eb == 0);
      s  = a[31] ^ b[31];
      flg  = '0;
      spec = 1'b1;
      res  = '0;
      if (an || bn || (az && bz) || (ai && bi)) begin
         res = QNAN;
         flg[FLAG_INVALID] = 1'b1;
      end else if (ai || bz) begin
         res = {s, 8'hFF, 23'h0};
         if (bz && !ai) flg[FLAG_DIV_BY_ZERO] = 1'b1;
      end else if (az || bi) begin
         res = {s, 31'h0};
      end else begin
         spec = 1'b0;
         ma  = 64'h80_0000 | 64'(a[22:0]);
         mb  = 64'h80_0000 | 64'(b[22:0]);
         num = ma << 25;
         q   = num / mb;
         r   = num % mb;
         e   = ea - eb + EXP_BIAS;
         if (q >= 64'h200_0000) begin
            mant = q >> 2;
            g    = q[1];
            st   = q[0] || (r != 0);
         end else begin
            mant = q >> 1;
            g    = q[0];
            st   = (r != 0);
            e    = e - 1;
         end
         if (g && (st || mant[0])) mant = mant + 1;
         if (mant == 64'h100_0000) begin
            mant = mant >> 1;
            e    = e + 1;
         end
         if (e >= 255) begin
            res = {s, 8'hFF, 23'h0};
            flg[FLAG_OVERFLOW] = 1'b1;
            flg[FLAG_INEXACT]  = 1'b1;
         end else if (e <= 0) begin
            res = {s, 31'h0};
            flg[FLAG_UNDERFLOW] = 1'b1;
            flg[FLAG_INEXACT]   = 1'b1;
         end else begin
            res = {s, e[7:0], mant[22:0]};
            flg[FLAG_INEXACT] = g | st;
         end
      end
   endfunction

   // One complete transaction. hold = cycles out_ready stays low once
   // out_valid is up; spam = keep in_valid high with other operands while busy.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit spam, input string tag);
      logic [31:0] er;
      logic [4:0]  ef;
      bit          sp;
      int          n;
      model(a, b, er, ef, sp);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "/idle"}, 32'(bus.in_ready), 32'd1);
      bus.floating1_in = a;
      bus.floating2_in = b;
      bus.in_valid     = 1'b1;
      @(posedge clk); #1;
      if (spam) begin
         bus.floating1_in = 32'h4120_0000;
         bus.floating2_in = 32'h3F80_0000;
      end else begin
         bus.in_valid = 1'b0;
      end
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (bus.out_valid !== 1'b1 && n < 60);
      bus.in_valid = 1'b0;
      check({tag, "/latency"}, 32'(n), sp ? 32'd2 : 32'd28);
      check({tag, "/result"}, bus.floating_division_out, er);
`ifdef FP_DIV_EXCEPTION_FLAGS_EN
      check({tag, "/flags"}, 32'(bus.flags), 32'(ef));
`endif
      check({tag, "/busy"}, 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "/hold_result"}, bus.floating_division_out, er);
         check({tag, "/hold_busy"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "/drained"}, 32'(bus.out_valid), 32'd0);
      check({tag, "/ready_again"}, 32'(bus.in_ready), 32'd1);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [7:0] e;
      if ($urandom_range(0, 9) < 8) e = 8'($urandom_range(60, 190));
      else                          e = 8'($urandom_range(0, 255));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   initial begin
      bit seen_valid;
      bus.in_valid     = 1'b0;
      bus.out_ready    = 1'b0;
      bus.floating1_in = '0;
      bus.floating2_in = '0;
      #12;
      check("reset/out_valid", 32'(bus.out_valid), 32'd0);
      check("reset/result", bus.floating_division_out, 32'h0);
      check("reset/in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(32'h4070_0000, 32'h3FC0_0000, 0, 1'b0, "3.75/1.5");
      run_op(32'h3F80_0000, 32'h4040_0000, 0, 1'b0, "1/3");
      run_op(32'hC0D0_0000, 32'h4000_0000, 0, 1'b0, "-6.5/2");
      run_op(32'hC080_0000, 32'hC000_0000, 0, 1'b0, "-4/-2");
      run_op(32'h40A0_0000, 32'h0000_0000, 0, 1'b0, "5/0");
      run_op(32'h0000_0000, 32'h0000_0000, 0, 1'b0, "0/0");
      run_op(32'h3F80_0000, 32'h7F80_0000, 0, 1'b0, "1/inf");
      run_op(32'h7F80_0000, 32'hFF80_0000, 0, 1'b0, "inf/inf");
      run_op(32'h7FA0_0001, 32'h3F80_0000, 0, 1'b0, "nan/1");
      run_op(32'hFF80_0000, 32'h4000_0000, 0, 1'b0, "-inf/2");
      run_op(32'h0040_0000, 32'h3F80_0000, 0, 1'b0, "denorm/1");
      run_op(32'h7F00_0000, 32'h3F00_0000, 0, 1'b0, "overflow");
      run_op(32'h0080_0000, 32'h4000_0000, 0, 1'b0, "underflow");
      run_op(32'h3FFF_FFFF, 32'h3F80_0001, 0, 1'b0, "carry_round");
      run_op(32'h4049_0FDB, 32'h402D_F854, 5, 1'b0, "backpressure");
      run_op(32'h4049_0FDB, 32'h4000_0000, 0, 1'b0, "back_to_back");
      run_op(32'h4110_0000, 32'h4040_0000, 2, 1'b1, "busy_in_valid");

      // Reset in the middle of DIV aborts the operation.
      bus.floating1_in = 32'h4070_0000;
      bus.floating2_in = 32'h3FC0_0000;
      bus.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset/out_valid", 32'(bus.out_valid), 32'd0);
      check("midreset/in_ready", 32'(bus.in_ready), 32'd1);
      check("midreset/result", bus.floating_division_out, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen_valid = 1'b1;
      end
      check("midreset/no_result", 32'(seen_valid), 32'd0);
      check("midreset/idle", 32'(bus.in_ready), 32'd1);
      run_op(32'h3F80_0000, 32'h4040_0000, 1, 1'b0, "after_reset");

      for (int k = 0; k < 60; k++) begin
         run_op(rand_operand(), rand_operand(), $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
